// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the M-extension group
    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StFix,
        StDone
    } state_e;

    // ALU control words; bit 4 selects subtract (b inverted, carry-in 1)
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b10000;

    // Carry flag position inside the ALU nzcv vector
    localparam int unsigned NZCV_C = 1;

    // Counter value of the final radix-2 iteration
    localparam logic [4:0] ITER_LAST = 5'd31;

    function automatic logic is_div(input op_e o);
        return o[2];
    endfunction

    function automatic logic is_rem(input op_e o);
        return (o == OpRem) || (o == OpRemu);
    endfunction

    function automatic logic rs1_signed(input op_e o);
        return (o == OpMulh) || (o == OpMulhsu) || (o == OpDiv) || (o == OpRem);
    endfunction

    function automatic logic rs2_signed(input op_e o);
        return (o == OpMulh) || (o == OpDiv) || (o == OpRem);
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU: add/sub plus logic ops and set-less-than, with nzcv flags.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  alu_control,
    output logic [31:0] result,
    output logic [3:0]  nzcv
);

    logic [31:0] b_eff;
    logic [31:0] sum;
    logic        carry;
    logic        overflow;

    // Shared adder; subtract is a + ~b + 1 so carry=1 means no borrow
    always_comb begin
        b_eff          = alu_control[4] ? ~b : b;
        {carry, sum}   = {1'b0, a} + {1'b0, b_eff} + 33'(alu_control[4]);
        overflow       = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    end

    // Result select and flag generation
    always_comb begin
        result = sum;
        unique case (alu_control[3:0])
            4'b0000: result = sum;
            4'b0001: result = a & b;
            4'b0010: result = a | b;
            4'b0011: result = a ^ b;
            4'b0101: result = {31'd0, sum[31] ^ overflow};
            default: result = sum;
        endcase
        nzcv = {result[31], result == 32'd0, carry, overflow};
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer built around a single adder/subtractor.
// Radix-2: sign magnitudes are formed first, 32 add/sub iterations run, then signs
// are restored in a single fix-up cycle.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    state_e          state;
    op_e             op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    // Multiply: hi/lo hold the running product, addend is |rs1|.
    // Divide: hi is the partial remainder, lo the dividend/quotient, addend is |rs2|.
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] addend;
    logic [4:0]      cnt;
    logic            neg_main;
    logic            neg_rem;

    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      alu_ctrl;
    logic [XLEN-1:0] alu_y;
    logic [3:0]      alu_nzcv;
    logic            alu_c;
    logic [2:0]      unused_nzcv;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_result;

    assign start_ready = (state == StIdle) && !flush;
    assign busy        = (state != StIdle);
    assign alu_c       = alu_nzcv[NZCV_C];
    assign unused_nzcv = {alu_nzcv[3:2], alu_nzcv[0]};

    // Operand magnitudes from the latched request
    always_comb begin
        rs1_neg = rs1_signed(op_q) && rs1_q[XLEN-1];
        rs2_neg = rs2_signed(op_q) && rs2_q[XLEN-1];
        rs1_mag = rs1_neg ? -rs1_q : rs1_q;
        rs2_mag = rs2_neg ? -rs2_q : rs2_q;
    end

    // ALU operands: add to the product high word, or trial-subtract from the shifted remainder
    always_comb begin
        alu_a    = hi;
        alu_b    = addend;
        alu_ctrl = ALU_ADD;
        if (is_div(op_q)) begin
            alu_a    = {hi[XLEN-2:0], lo[XLEN-1]};
            alu_ctrl = ALU_SUB;
        end
    end

    alu u_alu (
        .a           (alu_a),
        .b           (alu_b),
        .alu_control (alu_ctrl),
        .result      (alu_y),
        .nzcv        (alu_nzcv)
    );

    // Sign correction and word selection for the final result
    always_comb begin
        prod       = neg_main ? -{hi, lo} : {hi, lo};
        fix_result = prod[2*XLEN-1:XLEN];
        unique case (op_q)
            OpMul:                      fix_result = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  fix_result = prod[2*XLEN-1:XLEN];
            OpDiv:                      fix_result = neg_main ? -lo : lo;
            OpDivu:                     fix_result = lo;
            OpRem:                      fix_result = neg_rem ? -hi : hi;
            OpRemu:                     fix_result = hi;
            default:                    fix_result = prod[XLEN-1:0];
        endcase
    end

    // Sequencer FSM with registered result and handshake state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= StIdle;
            op_q         <= OpMul;
            rs1_q        <= '0;
            rs2_q        <= '0;
            hi           <= '0;
            lo           <= '0;
            addend       <= '0;
            cnt          <= '0;
            neg_main     <= 1'b0;
            neg_rem      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (flush) begin
            state        <= StIdle;
            cnt          <= '0;
            result_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_valid) begin
                        op_q  <= op_e'(op);
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        state <= StPrep;
                    end
                end
                StPrep: begin
                    if (is_div(op_q) && (rs2_q == '0)) begin
                        result       <= is_rem(op_q) ? rs1_q : '1;
                        result_valid <= 1'b1;
                        state        <= StDone;
                    end else begin
                        cnt      <= '0;
                        neg_main <= rs1_neg ^ rs2_neg;
                        neg_rem  <= rs1_neg;
                        hi       <= '0;
                        lo       <= is_div(op_q) ? rs1_mag : rs2_mag;
                        addend   <= is_div(op_q) ? rs2_mag : rs1_mag;
                        state    <= StIter;
                    end
                end
                StIter: begin
                    if (is_div(op_q)) begin
                        // Bit shifted out of hi makes the partial remainder 33 bits wide
                        if (hi[XLEN-1] || alu_c) begin
                            hi <= alu_y;
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= {hi[XLEN-2:0], lo[XLEN-1]};
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        if (lo[0]) begin
                            hi <= {alu_c, alu_y[XLEN-1:1]};
                            lo <= {alu_y[0], lo[XLEN-1:1]};
                        end else begin
                            hi <= {1'b0, hi[XLEN-1:1]};
                            lo <= {hi[0], lo[XLEN-1:1]};
                        end
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == ITER_LAST) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    result       <= fix_result;
                    result_valid <= 1'b1;
                    state        <= StDone;
                end
                StDone: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
